// File: rtl/uart_rx_pkg.sv
// Shared UART frame definitions: default baud divisor, frame geometry and receiver states.
// uart_rx and the transmitter both import this package.
package uart_rx_pkg;
   localparam int unsigned BAUD_END_DEF = 5208;
   localparam int unsigned BIT_END      = 10;
   localparam int unsigned DATA_W       = 8;

   localparam logic [3:0] START_IDX = 4'd0;
   localparam logic [3:0] STOP_IDX  = 4'd9;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RECV = 1'b1;
endpackage

// File: rtl/uart_rx_sync.sv
// Three-flop synchronizer for the asynchronous serial pin with falling-edge detect.
// The flops reset high so that releasing reset never looks like a start edge.
module uart_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic rs232_rx,
   output logic rx_s,
   output logic nedge
);
   logic rx_r1_q, rx_r2_q, rx_r3_q;
   logic rx_r1_d, rx_r2_d, rx_r3_d;

   always_comb begin
      rx_r1_d = rs232_rx;
      rx_r2_d = rx_r1_q;
      rx_r3_d = rx_r2_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rx_r1_q <= 1'b1;
      else        rx_r1_q <= rx_r1_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rx_r2_q <= 1'b1;
      else        rx_r2_q <= rx_r2_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rx_r3_q <= 1'b1;
      else        rx_r3_q <= rx_r3_d;
   end

   assign rx_s  = rx_r2_q;
   assign nedge = rx_r3_q & ~rx_r2_q;
endmodule

// File: rtl/uart_rx.sv
// 8N1 RS-232 receiver: mid-bit sampling, LSB first, one-cycle po_flag per good frame
// and one-cycle frame_err when the stop bit samples low.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int unsigned BAUD_END = BAUD_END_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rs232_rx,
   output logic [7:0] rx_data,
   output logic       po_flag,
   output logic       frame_err
);
   localparam logic [12:0] CNT0_END  = 13'(BAUD_END - 1);
   localparam logic [12:0] CNT0_MID  = 13'(BAUD_END / 2 - 1);
   localparam logic [3:0]  CNT1_LAST = 4'(BIT_END - 1);
   localparam logic [3:0]  DATA_LAST = 4'(DATA_W);

   logic rx_s, nedge;

   uart_rx_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .rs232_rx (rs232_rx),
      .rx_s     (rx_s),
      .nedge    (nedge)
   );

   logic [0:0]  flag_q, flag_d;
   logic [12:0] cnt0_q, cnt0_d;
   logic [3:0]  cnt1_q, cnt1_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        po_flag_q, po_flag_d;
   logic        frame_err_q, frame_err_d;

   logic       mid, end_cnt0, false_start, stop_mid, frame_done;
   logic [2:0] bit_idx;

   always_comb begin
      mid         = (flag_q == ST_RECV) && (cnt0_q == CNT0_MID);
      end_cnt0    = (flag_q == ST_RECV) && (cnt0_q == CNT0_END);
      false_start = mid && (cnt1_q == START_IDX) && rx_s;
      // Returning at mid-stop leaves half a bit to catch a back-to-back start edge.
      stop_mid    = mid && (cnt1_q == STOP_IDX);
      frame_done  = false_start || stop_mid;
      bit_idx     = 3'(cnt1_q - 4'd1);
   end

   always_comb begin
      flag_d = flag_q;
      if (frame_done)
         flag_d = ST_IDLE;
      else if ((flag_q == ST_IDLE) && nedge)
         flag_d = ST_RECV;
   end

   always_comb begin
      cnt0_d = cnt0_q + 13'd1;
      if (frame_done || (flag_q == ST_IDLE) || end_cnt0)
         cnt0_d = '0;
   end

   always_comb begin
      cnt1_d = cnt1_q;
      if (frame_done)
         cnt1_d = '0;
      else if (end_cnt0)
         cnt1_d = (cnt1_q == CNT1_LAST) ? 4'd0 : cnt1_q + 4'd1;
   end

   always_comb begin
      shift_d = shift_q;
      if (mid && (cnt1_q >= 4'd1) && (cnt1_q <= DATA_LAST))
         shift_d[bit_idx] = rx_s;
   end

   always_comb begin
      rx_data_d   = rx_data_q;
      po_flag_d   = stop_mid && rx_s;
      frame_err_d = stop_mid && !rx_s;
      if (stop_mid && rx_s)
         rx_data_d = shift_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) flag_q <= ST_IDLE;
      else        flag_q <= flag_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt0_q <= '0;
      else        cnt0_q <= cnt0_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt1_q <= '0;
      else        cnt1_q <= cnt1_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) shift_q <= '0;
      else        shift_q <= shift_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rx_data_q <= '0;
      else        rx_data_q <= rx_data_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) po_flag_q <= 1'b0;
      else        po_flag_q <= po_flag_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) frame_err_q <= 1'b0;
      else        frame_err_q <= frame_err_d;
   end

   assign rx_data   = rx_data_q;
   assign po_flag   = po_flag_q;
   assign frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized frames against a frame-level model of the receiver,
// with a behavioural transmitter on the echo path.
module tb_uart_rx;
   import uart_rx_pkg::*;

   localparam int unsigned BAUD = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rs232_rx = 1'b1;
   logic [7:0] rx_data;
   logic       po_flag;
   logic       frame_err;

   uart_rx #(.BAUD_END(BAUD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rs232_rx  (rs232_rx),
      .rx_data   (rx_data),
      .po_flag   (po_flag),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   // observed pulse activity
   int          po_cnt = 0, err_cnt = 0, both_cnt = 0, wide_cnt = 0;
   int unsigned po_cyc = 0;
   logic [7:0]  got_q[$];
   logic        prev_po = 1'b0, prev_err = 1'b0;

   always @(negedge clk) begin
      if (po_flag === 1'b1) begin
         po_cnt++;
         po_cyc = cyc;
         got_q.push_back(rx_data);
      end
      if (frame_err === 1'b1) err_cnt++;
      if (po_flag === 1'b1 && frame_err === 1'b1) both_cnt++;
      if ((po_flag === 1'b1 && prev_po) || (frame_err === 1'b1 && prev_err)) wide_cnt++;
      prev_po  = (po_flag === 1'b1);
      prev_err = (frame_err === 1'b1);
   end

   // behavioural transmitter fed from po_flag/rx_data
   logic        tx_line = 1'b1;
   logic        tx_active = 1'b0;
   int unsigned tx_start = 0;
   logic [9:0]  tx_frame;

   initial forever begin
      @(negedge clk);
      if (po_flag === 1'b1) begin
         tx_frame  = {1'b1, rx_data, 1'b0};
         tx_start  = cyc;
         tx_active = 1'b1;
         for (int i = 0; i < 10; i++) begin
            tx_line = tx_frame[i];
            repeat (BAUD) @(negedge clk);
         end
         tx_line   = 1'b1;
         tx_active = 1'b0;
      end
   end

   // frame-level reference model
   int          exp_po = 0, exp_err = 0;
   logic [7:0]  exp_data = 8'h00;
   logic [7:0]  exp_q[$];
   int unsigned frame_cyc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      frame_cyc = cyc;
      for (int i = 0; i < 10; i++) begin
         rs232_rx = f[i];
         repeat (BAUD) @(negedge clk);
      end
      rs232_rx = 1'b1;
      if (stop) begin
         exp_po++;
         exp_data = b;
         exp_q.push_back(b);
      end else begin
         exp_err++;
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, "_po_cnt"}, po_cnt, exp_po);
      check({tag, "_err_cnt"}, err_cnt, exp_err);
      check({tag, "_rx_data"}, rx_data, exp_data);
      check({tag, "_qlen"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0)
         check({tag, "_order"}, got_q.pop_front(), exp_q.pop_front());
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [7:0]  b;
      logic        stop;
      int unsigned gap;
      logic [9:0]  rf;
      int unsigned lat;
      int unsigned budget;

      repeat (4) @(negedge clk);
      check("reset_rx_data", rx_data, 8'h00);
      check("reset_po_flag", po_flag, 1'b0);
      check("reset_frame_err", frame_err, 1'b0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("post_reset_no_pulse", po_cnt + err_cnt, 0);

      // 1: single good frame, plus start-edge-to-po_flag latency
      send_frame(8'h55, 1'b1);
      lat = po_cyc - frame_cyc;
      check("latency_in_window", (lat >= 154 && lat <= 156), 1'b1);
      check_state("t1");
      repeat (8) @(negedge clk);

      // 2: back-to-back frames with zero idle
      send_frame(8'hA3, 1'b1);
      send_frame(8'h0F, 1'b1);
      repeat (8) @(negedge clk);
      check_state("t2");

      // 3: short low glitch is a false start
      rs232_rx = 1'b0;
      repeat (3) @(negedge clk);
      rs232_rx = 1'b1;
      repeat (40) @(negedge clk);
      check_state("t3_glitch");
      check("t3_flag_idle", dut.flag_q, 1'b0);
      send_frame(8'h81, 1'b1);
      repeat (8) @(negedge clk);
      check_state("t3");

      // 4: bad stop bit
      send_frame(8'h55, 1'b1);
      send_frame(8'hFF, 1'b0);
      repeat (20) @(negedge clk);
      check_state("t4");

      // 5: reset during data bit 4 of 0xC3
      frame_cyc = cyc;
      b = 8'hC3;
      rs232_rx = 1'b0;
      repeat (BAUD) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rs232_rx = b[i];
         repeat (BAUD) @(negedge clk);
      end
      rs232_rx = b[4];
      repeat (BAUD / 2) @(negedge clk);
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      check("t5_rst_rx_data", rx_data, 8'h00);
      check("t5_rst_po_flag", po_flag, 1'b0);
      check("t5_rst_flag", dut.flag_q, 1'b0);
      rs232_rx = 1'b1;
      rst_n = 1'b1;
      exp_data = 8'h00;
      repeat (20) @(negedge clk);
      check_state("t5_abort");
      send_frame(8'h3C, 1'b1);
      repeat (8) @(negedge clk);
      check_state("t5");

      // randomized frames
      for (int n = 0; n < 12; n++) begin
         b    = 8'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         gap  = stop ? $urandom_range(0, 12) : 20 + $urandom_range(0, 12);
         send_frame(b, stop);
         check_state("rand");
         repeat (gap) @(negedge clk);
      end

      // 6: echo path through the behavioural transmitter
      repeat (200) @(negedge clk);
      send_frame(8'h7E, 1'b1);
      budget = 0;
      while (!tx_active && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      check("t6_tx_started", tx_active, 1'b1);
      for (int i = 0; i < 10; i++) begin
         budget = 0;
         while (cyc < tx_start + 16 * i + 8 && budget < 400) begin
            @(negedge clk);
            budget++;
         end
         rf[i] = tx_line;
      end
      check("t6_tx_start_bit", rf[0], 1'b0);
      check("t6_tx_data", rf[8:1], 8'h7E);
      check("t6_tx_stop_bit", rf[9], 1'b1);
      repeat (20) @(negedge clk);
      check_state("t6");

      check("pulses_never_together", both_cnt, 0);
      check("pulses_one_cycle", wide_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
